// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle terminal-count pulse.
// Loads a start value and decrements once per enabled clock.
// The start value saturates at LIMITE-1.
// Configuration macro COUNTDOWN_AUTO_RELOAD_EN:
//   defined   - on terminal count the last load value is reloaded and the
//               timer keeps running.
//   undefined - one-shot: the count drops to 0 and the timer goes idle.
module countdown_timer #(
  parameter int WIDTH  = 4,
  parameter int LIMITE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] out_counter,
  output logic             done,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MAX_LV = WIDTH'(LIMITE - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  // Clamp a requested start value to the largest legal count.
  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
    return (v > MAX_LV) ? MAX_LV : v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lv;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Only the reloading build ever reads back the last load value, so the
  // register exists only there.
  logic [WIDTH-1:0] reload_reg_q, reload_reg_d;
`endif

  // Next-state logic. Load beats terminal count, which beats decrement.
  always_comb begin
    lv      = sat_load(load_value);
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_reg_d = reload_reg_q;
`endif
    if (load) begin
      cnt_d   = lv;
      state_d = (lv != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_reg_d = lv;
`endif
    end else if (state_q == RUN && enable) begin
      // Terminal count is detected at 1, so the decrement never wraps.
      // The <= also catches a zero count, which RUN should never hold.
      if (cnt_q <= ONE) begin
        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        cnt_d   = reload_reg_q;
        state_d = RUN;
`else
        cnt_d   = '0;
        state_d = IDLE;
`endif
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // State, count and pulse registers. Reset asserts asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // Last effective load value. After reset it holds the largest legal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload_reg_q <= MAX_LV;
    end else begin
      reload_reg_q <= reload_reg_d;
    end
  end
`endif

  assign out_counter = cnt_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer, built with WIDTH=4 and LIMITE=10.
// Each step pushes the expected post-edge outputs and pops them after the edge.
module tb_countdown_timer;

  localparam int WIDTH  = 4;
  localparam int LIMITE = 10;

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic             done;
    logic             busy;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] out_counter;
  logic             done;
  logic             busy;

  exp_t q[$];
  int   n_checks;
  int   n_fail;

  countdown_timer #(.WIDTH(WIDTH), .LIMITE(LIMITE)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .out_counter(out_counter),
    .done       (done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_now(input string tag, input exp_t e);
    n_checks++;
    assert (out_counter === e.cnt) else begin
      n_fail++;
      $error("FAIL %s out_counter: observed %0d expected %0d", tag, out_counter, e.cnt);
    end
    n_checks++;
    assert (done === e.done) else begin
      n_fail++;
      $error("FAIL %s done: observed %b expected %b", tag, done, e.done);
    end
    n_checks++;
    assert (busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, e.busy);
    end
  endtask

  // Drive one cycle of inputs, queue the expected result, clock, then compare.
  task automatic step(input string tag, input logic ld, input int lvv, input logic en,
                      input int ecnt, input logic edone, input logic ebusy);
    exp_t e;
    load       = ld;
    load_value = WIDTH'(lvv);
    enable     = en;
    q.push_back('{cnt: WIDTH'(ecnt), done: edone, busy: ebusy});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_now(tag, e);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b0;
    load       = 1'b0;
    load_value = '0;
    enable     = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_init", '{cnt: 4'd0, done: 1'b0, busy: 1'b0});
    reset = 1'b1;

    // Reset mid-run: load 7 and hold it, then pull reset between edges
    step("rst_load7", 1'b1, 7, 1'b0, 7, 1'b0, 1'b1);
    step("rst_hold7", 1'b0, 0, 1'b0, 7, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_now("rst_async", '{cnt: 4'd0, done: 1'b0, busy: 1'b0});
    @(negedge clk);
    reset = 1'b1;
    step("rst_idle_a", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);
    step("rst_idle_b", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);

    // Saturation and zero load
    step("sat_15", 1'b1, 15, 1'b0, 9, 1'b0, 1'b1);
    step("sat_hold", 1'b0, 0, 1'b0, 9, 1'b0, 1'b1);
    step("zero_load", 1'b1, 0, 1'b0, 0, 1'b0, 1'b0);
    step("zero_idle_en", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);

    // Collision: load on the terminal-count cycle wins
    step("col_load2", 1'b1, 2, 1'b1, 2, 1'b0, 1'b1);
    step("col_at1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    step("col_load6", 1'b1, 6, 1'b1, 6, 1'b0, 1'b1);
    step("col_dec", 1'b0, 0, 1'b1, 5, 1'b0, 1'b1);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // One-shot count 5,4,3,2,1,0
    step("os_load5", 1'b1, 5, 1'b1, 5, 1'b0, 1'b1);
    step("os_4", 1'b0, 0, 1'b1, 4, 1'b0, 1'b1);
    step("os_3", 1'b0, 0, 1'b1, 3, 1'b0, 1'b1);
    step("os_2", 1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
    step("os_1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    step("os_term", 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
    step("os_hold0", 1'b0, 0, 1'b1, 0, 1'b0, 1'b0);

    // Enable gating: hold at 3 for three cycles, then resume
    step("en_load4", 1'b1, 4, 1'b1, 4, 1'b0, 1'b1);
    step("en_3", 1'b0, 0, 1'b1, 3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step("en_gate", 1'b0, 0, 1'b0, 3, 1'b0, 1'b1);
    step("en_2", 1'b0, 0, 1'b1, 2, 1'b0, 1'b1);
    step("en_1", 1'b0, 0, 1'b1, 1, 1'b0, 1'b1);
    step("en_term", 1'b0, 0, 1'b1, 0, 1'b1, 1'b0);
`else
    // Auto-reload: 3,2,1,3,... with done on every reload
    begin
      int pulses;
      int exp_cnt;
      pulses  = 0;
      exp_cnt = 3;
      step("ar_load3", 1'b1, 3, 1'b1, 3, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) begin
        logic exp_done;
        exp_done = (exp_cnt == 1);
        exp_cnt  = (exp_cnt == 1) ? 3 : exp_cnt - 1;
        step("ar_run", 1'b0, 0, 1'b1, exp_cnt, exp_done, 1'b1);
        if (done === 1'b1) pulses++;
      end
      n_checks++;
      assert (pulses == 4) else begin
        n_fail++;
        $error("FAIL ar_pulses: observed %0d expected 4", pulses);
      end
    end
`endif

    n_checks++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL queue_empty: observed %0d expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Programmable down-counter complementing the free-running up `counter`. It loads a start value, decrements once per enabled clock, and flags terminal count with a one-cycle `done` pulse. Game logic uses it for frame timers, sprite animation delays and input debounce windows. It sits beside `counter` in the timing/utility layer and shares its parameter style (`WIDTH`, `LIMITE`).

## Interface
- `WIDTH`, 4: counter and load width in bits.
- `LIMITE`, 16: count modulus. Maximum loadable value is `LIMITE-1`. Must satisfy `2 <= LIMITE <= 2**WIDTH`.

- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset. Assert is immediate; release is synchronous to `clk`.
- `load`  input  1  load strobe, sampled at rising edge.
- `load_value`  input  WIDTH  start value captured on `load`.
- `enable`  input  1  count enable; the counter decrements only when high.
- `out_counter`  output  WIDTH  current count, registered.
- `done`  output  1  registered one-cycle terminal-count pulse.
- `busy`  output  1  high while in RUN, decoded from the state register.

## Operation
- **States:**
  - IDLE: holds `out_counter`.
  - RUN: counts down.
- **Internal register `reload_reg` (WIDTH bits):**
  - Holds the last effective load value.
  - Reset value is `LIMITE-1`.
- **Load saturation:** the effective load value `lv` is `load_value` if `load_value <= LIMITE-1`, otherwise `LIMITE-1`.
- **Priority, highest first:** reset, then `load`, then terminal count, then decrement.
- **`load`, any state:**
  - `out_counter <= lv` and `reload_reg <= lv`.
  - Next state is RUN if `lv != 0`, otherwise IDLE.
  - `done` is 0 on that cycle.
- **RUN, `enable`=0:** `out_counter` holds, the state holds, and `done`=0.
- **RUN, `enable`=1, `out_counter > 1`:** `out_counter <= out_counter - 1`.
- **RUN, `enable`=1, `out_counter == 1`:** terminal count.
  - `done <= 1` for exactly one cycle.
  - The next count and state depend on Configuration.
- **IDLE:**
  - `enable` is ignored.
  - `done` is 0 except on the cycle after a terminal count.
- **Arithmetic:**
  - Decrement is unsigned, WIDTH bits.
  - Underflow is impossible because terminal detection occurs at 1.
- **Reset mid-count:** all outputs and state return to their reset values immediately, without waiting for a clock edge.

## Timing
- **Reset values:**
  - `out_counter`=0
  - `done`=0
  - `busy`=0
  - state=IDLE
  - `reload_reg`=`LIMITE-1`
- **Load latency:** `load` at edge k produces `out_counter`=`lv` and `busy`=1 after edge k.
- **Count to terminal:** with `enable` held high from edge k+1, `done` is high during the cycle after edge k+`lv`, for exactly one cycle.
- **Load and terminal count in the same cycle:** load wins. The new value is taken and no `done` is produced.
- **`busy` deassertion:** `busy` falls on the same edge that raises `done` (non-reload build only).

## Configuration
- **Macro `COUNTDOWN_AUTO_RELOAD_EN`.**
- **Defined (auto-reload):**
  - On terminal count: `out_counter <= reload_reg` and the state stays RUN.
  - `done` therefore pulses every `reload_reg` enabled cycles.
  - `out_counter` never displays 0 while running.
- **Undefined (one-shot):**
  - On terminal count: `out_counter <= 0` and the state goes to IDLE.
  - The timer stays idle until the next `load`.

## Test plan
- **Reset:**
  - Stimulus: drive `reset`=0 mid-run with `out_counter`=7.
  - Response: `out_counter`=0, `busy`=0 and `done`=0 immediately, before any clock edge. After release with no `load`, the block stays IDLE.
- **One-shot count:**
  - Stimulus: `load_value`=5 and `enable`=1.
  - Response: `out_counter` sequence is 5,4,3,2,1,0.
  - `done`=1 only in the cycle `out_counter` first reads 0; `busy` falls on that same edge; the count holds at 0.
- **Enable gating:**
  - Stimulus: load 4, then drop `enable` for 3 cycles while `out_counter`=3.
  - Response: the value holds at 3 and `done` is not asserted. The countdown resumes when `enable` returns.
- **Saturation and zero load:**
  - `load_value`=15 with `LIMITE`=10 and `WIDTH`=4 loads 9.
  - `load_value`=0 leaves the block IDLE, with `busy`=0 and `done`=0.
- **Collision:**
  - Stimulus: assert `load` with `load_value`=6 on the cycle `out_counter`=1 and `enable`=1.
  - Response: `out_counter`=6, no `done`, `busy` stays 1.
- **Auto-reload (macro defined):**
  - Stimulus: load 3, then hold `enable`=1 for 12 cycles.
  - Response: sequence is 3,2,1,3,2,1,…
  - `done` pulses every 3 cycles, 4 pulses in total; `busy` stays 1 throughout.
